sm_reg_dump_tx: RTL and testbench

//   Register-dump transmitter for the board debug path. On a start request it walks
//   the core's debug register read port (regAddr/regData) from address 0 to REG_COUNT-1.
//   It sends a header byte, then every register value, over a UART 8N1 TX line to the host.
//   It is the transmit counterpart of the LED register readout and sits beside sm_top in

---
 rtl/sm_reg_dump_tx.sv | 194 +++++++++++++++++++
 tb/tb_sm_reg_dump_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sm_reg_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sm_reg_dump_tx
//  Description : Register-dump transmitter. On a start request it walks the
//                debug register read port from address 0 to REG_COUNT-1 and
//                sends a sync header byte followed by every register value,
//                most-significant byte first, over a UART 8N1 TX line.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_reg_dump_tx #(
  parameter int         DATA_W       = 32,
  parameter int         ADDR_W       = 5,
  parameter int         REG_COUNT    = 32,
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [DATA_W-1:0] regData,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  // Derived sizes and terminal counts
  localparam int C_BYTES = DATA_W / 8;
  localparam int C_CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int C_BC_W  = $clog2(C_BYTES + 1);

  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
  localparam logic [3:0]         C_BIT_STOP = 4'd9;
  localparam logic [3:0]         C_BIT_LAST_DATA = 4'd8;
  localparam logic [C_BC_W-1:0]  C_BC_FULL  = C_BC_W'(C_BYTES);
  localparam logic [C_BC_W-1:0]  C_BC_ONE   = C_BC_W'(1);
  localparam logic [ADDR_W-1:0]  C_ADDR_LAST = ADDR_W'(REG_COUNT - 1);
  localparam logic [ADDR_W-1:0]  C_ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_BYTE = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [C_CNT_W-1:0]  r_clk_cnt;   // cycles elapsed within the current bit
  logic [3:0]          r_bit_idx;   // 0 = start, 1..8 = data LSB first, 9 = stop
  logic [C_BC_W-1:0]   r_byte_cnt;  // bytes of the current register still to send
  logic [DATA_W-1:0]   r_shreg;     // register snapshot, current byte in the top 8 bits
  logic [ADDR_W-1:0]   r_addr;

  logic                w_in_frame;
  logic                w_bit_end;
  logic                w_frame_end;
  logic                w_last_byte;
  logic                w_last_reg;
  logic [7:0]          w_cur_byte;
  logic [2:0]          w_data_sel;
  logic                w_tx;
  logic                w_busy;
  logic                w_done;

  assign w_in_frame  = (r_state == S_HDR) || (r_state == S_BYTE);
  assign w_bit_end   = (r_clk_cnt == C_CNT_LAST);
  assign w_frame_end = w_in_frame && w_bit_end && (r_bit_idx == C_BIT_STOP);
  assign w_last_byte = (r_byte_cnt == C_BC_ONE);
  assign w_last_reg  = (r_addr == C_ADDR_LAST);
  assign w_cur_byte  = (r_state == S_HDR) ? HEADER : r_shreg[DATA_W-1 -: 8];
  assign w_data_sel  = 3'(r_bit_idx - 4'd1);

  // State register; reset returns to IDLE immediately, even mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_HDR;
        end
      end
      S_HDR: begin
        w_busy = 1'b1;
        if (w_frame_end) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_busy = 1'b1;
        w_next = S_BYTE;
      end
      S_BYTE: begin
        w_busy = 1'b1;
        if (w_frame_end && w_last_byte) begin
          w_next = w_last_reg ? S_FIN : S_LOAD;
        end
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Serial line value: start bit, 8 data bits LSB first, stop bit; idle high
  always_comb begin
    w_tx = 1'b1;
    if (w_in_frame) begin
      if (r_bit_idx == 4'd0) begin
        w_tx = 1'b0;
      end else if (r_bit_idx <= C_BIT_LAST_DATA) begin
        w_tx = w_cur_byte[w_data_sel];
      end
    end
  end

  // Bit timing: count cycles per bit and advance through the 10 bit slots;
  // frames run back to back because the index wraps straight to the start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
    end else if (w_in_frame) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        r_bit_idx <= (r_bit_idx == C_BIT_STOP) ? 4'd0 : r_bit_idx + 4'd1;
      end else begin
        r_clk_cnt <= r_clk_cnt + C_CNT_ONE;
      end
    end else begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
    end
  end

  // Register snapshot at the end of LOAD, then shift out one byte per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_byte_cnt <= '0;
    end else if (r_state == S_LOAD) begin
      r_shreg    <= regData;
      r_byte_cnt <= C_BC_FULL;
    end else if ((r_state == S_BYTE) && w_frame_end) begin
      r_shreg    <= r_shreg << 8;
      r_byte_cnt <= r_byte_cnt - C_BC_ONE;
    end
  end

  // Register address walk: step after each register's last byte, park at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else begin
      case (r_state)
        S_BYTE: begin
          if (w_frame_end && w_last_byte) begin
            r_addr <= w_last_reg ? '0 : r_addr + C_ADDR_ONE;
          end
        end
        S_HDR, S_LOAD: begin
          r_addr <= r_addr;
        end
        default: begin
          r_addr <= '0;
        end
      endcase
    end
  end

  assign regAddr = r_addr;
  assign tx      = w_tx;
  assign busy    = w_busy;
  assign done    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_sm_reg_dump_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_reg_dump_tx
//  Description : Self-checking bench for sm_reg_dump_tx. Three instances cover
//                the default dump, a single-register dump and a one-cycle-per-
//                bit dump. Expected line waveforms are built from frame rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_reg_dump_tx;

  logic        clk;
  logic        rst_n;
  logic        start   [3];
  logic [4:0]  regAddr [3];
  logic [31:0] regData [3];
  logic        tx      [3];
  logic        busy    [3];
  logic        done    [3];
  logic [31:0] mem     [3][32];

  int n_vec;
  int n_err;
  bit exp_q[$];

  assign regData[0] = mem[0][regAddr[0]];
  assign regData[1] = mem[1][regAddr[1]];
  assign regData[2] = mem[2][regAddr[2]];

  sm_reg_dump_tx #(.DATA_W(32), .ADDR_W(5), .REG_COUNT(32), .CLKS_PER_BIT(4), .HEADER(8'hA5)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .regAddr(regAddr[0]), .regData(regData[0]),
    .tx(tx[0]), .busy(busy[0]), .done(done[0]));

  sm_reg_dump_tx #(.DATA_W(32), .ADDR_W(5), .REG_COUNT(1), .CLKS_PER_BIT(4), .HEADER(8'hA5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .regAddr(regAddr[1]), .regData(regData[1]),
    .tx(tx[1]), .busy(busy[1]), .done(done[1]));

  sm_reg_dump_tx #(.DATA_W(32), .ADDR_W(5), .REG_COUNT(2), .CLKS_PER_BIT(1), .HEADER(8'hA5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .regAddr(regAddr[2]), .regData(regData[2]),
    .tx(tx[2]), .busy(busy[2]), .done(done[2]));

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One UART frame on the line: each bit held for cpb cycles
  task automatic push_frame(input logic [7:0] b, input int cpb);
    for (int j = 0; j < 10; j++) begin
      bit v;
      if (j == 0)      v = 1'b0;
      else if (j == 9) v = 1'b1;
      else             v = b[j-1];
      repeat (cpb) exp_q.push_back(v);
    end
  endtask

  // Whole expected busy-window waveform: header frame, then per register one
  // idle-high load cycle followed by its four bytes MSB first
  task automatic build_exp(input int k, input int cpb, input int rc);
    exp_q.delete();
    push_frame(8'hA5, cpb);
    for (int r = 0; r < rc; r++) begin
      exp_q.push_back(1'b1);
      for (int by = 3; by >= 0; by--) push_frame(mem[k][r][8*by +: 8], cpb);
    end
  endtask

  // Called at the first negedge after start was accepted. Compares the line
  // each cycle, then the FIN cycle and the following IDLE cycle.
  task automatic watch_dump(input int k, input bit pulses, input int abort_at);
    int n;
    n = 0;
    check_value("busy_rise", busy[k], 1);
    while (busy[k] === 1'b1 && n < exp_q.size() + 16) begin
      if (n < exp_q.size()) check_value("tx_bit", tx[k], exp_q[n]);
      if (n == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_value("rst_tx", tx[k], 1);
        check_value("rst_busy", busy[k], 0);
        check_value("rst_addr", regAddr[k], 0);
        check_value("rst_done", done[k], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (pulses) start[k] = (n == 10 || n == 3000);
      n++;
      @(negedge clk);
    end
    if (pulses) start[k] = 1'b0;
    check_value("busy_len", n, exp_q.size());
    check_value("fin_done", done[k], 1);
    check_value("fin_addr", regAddr[k], 0);
    check_value("fin_tx", tx[k], 1);
    @(negedge clk);
    check_value("idle_done", done[k], 0);
    check_value("idle_busy", busy[k], 0);
    check_value("idle_tx", tx[k], 1);
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      for (int i = 0; i < 32; i++) mem[k][i] = 32'(i);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_value("reset_tx", tx[k], 1);
      check_value("reset_busy", busy[k], 0);
      check_value("reset_done", done[k], 0);
      check_value("reset_addr", regAddr[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Counting pattern reg[n] = n, single start pulse
    build_exp(0, 4, 32);
    pulse_start(0);
    watch_dump(0, 1'b0, -1);

    // Random register contents
    for (int i = 0; i < 32; i++) mem[0][i] = $urandom;
    build_exp(0, 4, 32);
    pulse_start(0);
    watch_dump(0, 1'b0, -1);

    // Single register, bit-exact frame check of 80 00 00 01, then random
    mem[1][0] = 32'h8000_0001;
    build_exp(1, 4, 1);
    pulse_start(1);
    watch_dump(1, 1'b0, -1);
    mem[1][0] = $urandom;
    build_exp(1, 4, 1);
    pulse_start(1);
    watch_dump(1, 1'b0, -1);

    // Start pulses while busy are ignored
    for (int i = 0; i < 32; i++) mem[0][i] = 32'(i);
    build_exp(0, 4, 32);
    pulse_start(0);
    watch_dump(0, 1'b1, -1);

    // Start held high: two dumps with a single IDLE cycle in between
    for (int i = 0; i < 32; i++) mem[0][i] = $urandom;
    build_exp(0, 4, 32);
    start[0] = 1'b1;
    @(negedge clk);
    watch_dump(0, 1'b0, -1);
    @(negedge clk);
    start[0] = 1'b0;
    watch_dump(0, 1'b0, -1);

    // Reset during 3rd bit of register 5, byte 2; restart afterwards
    build_exp(0, 4, 32);
    pulse_start(0);
    watch_dump(0, 1'b0, 40 + 5*161 + 1 + 40 + 2*4 + 1);
    check_value("post_rst_tx", tx[0], 1);
    check_value("post_rst_busy", busy[0], 0);
    pulse_start(0);
    watch_dump(0, 1'b0, -1);

    // One cycle per bit, two registers
    for (int r = 0; r < 3; r++) begin
      mem[2][0] = $urandom;
      mem[2][1] = $urandom;
      build_exp(2, 1, 2);
      pulse_start(2);
      watch_dump(2, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
